// File: rtl/sync_pkg.sv
// Shared types and width helper for the sync period lock path.
package sync_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2,
        HOLD  = 2'd3
    } sync_state_e;

    // Ceiling log2 with clog2(1) = 0; used to size counters from parameters.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_cmp.sv
// Compares rising edges of the raw sync stream against its one-period-delayed
// copy and emits combinational match/miss strobes for the lock FSM.
module sync_edge_cmp
    import sync_pkg::*;
#(
    parameter int unsigned LENGTH = 8192,
    parameter int unsigned TOL    = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clk_en_i,
    input  logic in_i,
    input  logic dly_i,
    input  logic active_i,
    output logic dly_rise_o,
    output logic match_o,
    output logic miss_o
);

    localparam int unsigned SW = clog2(TOL + 2);
    localparam int unsigned WW = clog2(LENGTH + TOL + 1);
    localparam logic [SW-1:0] SINCE_SAT = SW'(TOL);
    localparam logic [SW-1:0] WIN_LAST  = (TOL == 0) ? '0 : SW'(TOL - 1);
    localparam logic [WW-1:0] WD_LIM    = WW'(LENGTH + TOL);

    logic          in_q, dly_q, pend_q, pend_d;
    logic [SW-1:0] since_q, since_d, rem_q, rem_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          in_rise, dly_rise;

    assign in_rise    = in_i & ~in_q;
    assign dly_rise   = dly_i & ~dly_q;
    assign dly_rise_o = dly_rise;

    always_comb begin
        match_o = 1'b0;
        miss_o  = 1'b0;
        pend_d  = pend_q;
        rem_d   = rem_q;
        wd_d    = wd_q;
        // since_q counts cycles after the rise, so since_q < TOL means "within TOL".
        if (in_rise)                since_d = '0;
        else if (since_q == SINCE_SAT) since_d = since_q;
        else                        since_d = since_q + 1'b1;

        if (pend_q) begin
            if (dly_rise) begin
                miss_o = 1'b1;
                pend_d = 1'b0;
            end else if (in_rise) begin
                match_o = 1'b1;
                pend_d  = 1'b0;
            end else if (rem_q == '0) begin
                miss_o = 1'b1;
                pend_d = 1'b0;
            end else begin
                rem_d = rem_q - 1'b1;
            end
        end

        if (dly_rise) begin
            wd_d = WW'(1);
            if (in_rise || (since_q < SINCE_SAT)) begin
                match_o = 1'b1;
            end else if (TOL == 0) begin
                miss_o = 1'b1;
            end else begin
                pend_d = 1'b1;
                rem_d  = WIN_LAST;
            end
        end else if (wd_q == WD_LIM) begin
            if (active_i) begin
                miss_o = 1'b1;
                wd_d   = WW'(1);
            end
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_q    <= 1'b0;
            dly_q   <= 1'b0;
            since_q <= SINCE_SAT;
            pend_q  <= 1'b0;
            rem_q   <= '0;
            wd_q    <= '0;
        end else if (clk_en_i) begin
            in_q    <= in_i;
            dly_q   <= dly_i;
            since_q <= since_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: rtl/sync_period_lock.sv
// Lock FSM and flywheel sync regenerator fed by the edge comparator.
module sync_period_lock
    import sync_pkg::*;
#(
    parameter int unsigned LENGTH     = 8192,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       in,
    input  logic       dly,
    output logic [1:0] state,
    output logic       locked,
    output logic       match,
    output logic       miss,
    output logic       sync_out
);

    localparam int unsigned HW = clog2(LOCK_CNT + 1);
    localparam int unsigned MW = clog2(UNLOCK_CNT + 1);
    localparam int unsigned FW = clog2(LENGTH + 1);
    localparam logic [FW-1:0] FW_LAST = FW'(LENGTH - 1);

    sync_state_e   state_q, state_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [MW-1:0] misses_q, misses_d;
    logic [FW-1:0] fw_q, fw_d;
    logic          match_q, miss_q, sync_q, sync_d;
    logic          dly_rise, match_s, miss_s, in_lock;

    assign in_lock = (state_q == LOCK) || (state_q == HOLD);

    sync_edge_cmp #(
        .LENGTH (LENGTH),
        .TOL    (TOL)
    ) u_cmp (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clk_en_i   (clk_en),
        .in_i       (in),
        .dly_i      (dly),
        .active_i   (state_q != HUNT),
        .dly_rise_o (dly_rise),
        .match_o    (match_s),
        .miss_o     (miss_s)
    );

    // A stale-window miss and a fresh match can share a cycle: apply miss first.
    always_comb begin
        state_d  = state_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (miss_s) begin
            case (state_d)
                CHECK: begin
                    state_d = HUNT;
                    hits_d  = '0;
                end
                LOCK: begin
                    if (UNLOCK_CNT == 1) begin
                        state_d = HUNT;
                    end else begin
                        state_d  = HOLD;
                        misses_d = MW'(1);
                    end
                end
                HOLD: begin
                    if (32'(misses_d) + 1 >= UNLOCK_CNT) begin
                        state_d  = HUNT;
                        misses_d = '0;
                    end else begin
                        misses_d = misses_d + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (match_s) begin
            case (state_d)
                HUNT: begin
                    if (LOCK_CNT == 1) begin
                        state_d = LOCK;
                        hits_d  = '0;
                    end else begin
                        state_d = CHECK;
                        hits_d  = HW'(1);
                    end
                end
                CHECK: begin
                    if (32'(hits_d) + 1 >= LOCK_CNT) begin
                        state_d = LOCK;
                        hits_d  = '0;
                    end else begin
                        hits_d = hits_d + 1'b1;
                    end
                end
                HOLD: begin
                    state_d  = LOCK;
                    misses_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fw_d   = '0;
        sync_d = 1'b0;
        if (in_lock) begin
            if (dly_rise || (fw_q == FW_LAST)) sync_d = 1'b1;
            else                               fw_d   = fw_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            hits_q   <= '0;
            misses_q <= '0;
            fw_q     <= '0;
            match_q  <= 1'b0;
            miss_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            fw_q     <= fw_d;
            match_q  <= match_s;
            miss_q   <= miss_s;
            sync_q   <= sync_d;
        end else begin
            match_q <= 1'b0;
            miss_q  <= 1'b0;
            sync_q  <= 1'b0;
        end
    end

    assign state    = state_q;
    assign locked   = in_lock;
    assign match    = match_q;
    assign miss     = miss_q;
    assign sync_out = sync_q;

endmodule

// File: tb/tb_sync_period_lock.sv
// Randomised directed scenarios for sync_period_lock checked against a
// timestamp-based reference model of the lock rules.
module tb_sync_period_lock;

    localparam int LENGTH     = 16;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       in = 1'b0;
    logic       dly = 1'b0;
    logic [1:0] state;
    logic       locked, match, miss, sync_out;

    sync_period_lock #(
        .LENGTH     (LENGTH),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .in       (in),
        .dly      (dly),
        .state    (state),
        .locked   (locked),
        .match    (match),
        .miss     (miss),
        .sync_out (sync_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural delay line: dl[LENGTH-1] is the input LENGTH enabled samples ago.
    logic [LENGTH-1:0] dl = '0;

    // Reference model state: absolute enabled-cycle timestamps.
    int   n = 0;
    logic m_prev_in = 1'b0, m_prev_dly = 1'b0;
    int   last_in = -100000, last_dly = -100000, last_sync = 0, deadline = 0;
    bit   pend = 1'b0;
    int   st = 0, hits = 0, misses = 0;
    logic [1:0] e_state = 2'd0;
    logic e_match = 1'b0, e_miss = 1'b0, e_sync = 1'b0;
    bit   half_en = 1'b0;

    task automatic model_step(input logic r, input logic en, input logic iv, input logic dv);
        bit ir, dr, mt, ms;
        if (!r) begin
            m_prev_in = 1'b0; m_prev_dly = 1'b0;
            last_in = -100000; last_dly = -100000; pend = 1'b0;
            st = 0; hits = 0; misses = 0;
            e_state = 2'd0; e_match = 1'b0; e_miss = 1'b0; e_sync = 1'b0;
            return;
        end
        e_match = 1'b0; e_miss = 1'b0; e_sync = 1'b0;
        if (!en) return;
        n++;
        ir = iv && !m_prev_in;
        dr = dv && !m_prev_dly;
        mt = 1'b0; ms = 1'b0;
        if (pend) begin
            if (dr)                 begin ms = 1'b1; pend = 1'b0; end
            else if (ir)            begin mt = 1'b1; pend = 1'b0; end
            else if (n == deadline) begin ms = 1'b1; pend = 1'b0; end
        end
        if (dr) begin
            if (ir || (n - last_in <= TOL)) mt = 1'b1;
            else begin pend = 1'b1; deadline = n + TOL; end
            last_dly = n;
        end else if (st != 0 && (n - last_dly == LENGTH + TOL)) begin
            ms = 1'b1;
            last_dly = n;
        end
        if (ir) last_in = n;
        if (st >= 2) begin
            if (dr || (n - last_sync == LENGTH)) begin e_sync = 1'b1; last_sync = n; end
        end else begin
            last_sync = n;
        end
        if (ms) begin
            if (st == 1) begin st = 0; hits = 0; end
            else if (st == 2) begin
                misses = 1;
                st = (UNLOCK_CNT == 1) ? 0 : 3;
                if (st == 0) misses = 0;
            end else if (st == 3) begin
                misses++;
                if (misses >= UNLOCK_CNT) begin st = 0; misses = 0; end
            end
        end
        if (mt) begin
            if (st == 0) begin
                hits = 1;
                st = (LOCK_CNT == 1) ? 2 : 1;
            end else if (st == 1) begin
                hits++;
                if (hits >= LOCK_CNT) begin st = 2; hits = 0; end
            end else if (st == 3) begin
                st = 2; misses = 0;
            end
        end
        e_match = mt; e_miss = ms; e_state = 2'(st);
        m_prev_in = iv; m_prev_dly = dv;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic iv);
        logic dv;
        @(negedge clk);
        dv     = dl[LENGTH-1];
        rst_n  = r;
        clk_en = en;
        in     = iv;
        dly    = dv;
        model_step(r, en, iv, dv);
        @(posedge clk);
        #1;
        if (en) dl = {dl[LENGTH-2:0], iv};
        check("state",    state,          e_state);
        check("locked",   {1'b0, locked}, {1'b0, (e_state >= 2'd2)});
        check("match",    {1'b0, match},  {1'b0, e_match});
        check("miss",     {1'b0, miss},   {1'b0, e_miss});
        check("sync_out", {1'b0, sync_out}, {1'b0, e_sync});
    endtask

    // One enabled cycle, preceded by a disabled cycle with random input when half_en.
    task automatic en_cycle(input logic iv);
        if (half_en) step(1'b1, 1'b0, 1'(($urandom) & 1));
        step(1'b1, 1'b1, iv);
    endtask

    task automatic pulse_after(input int gap);
        for (int i = 0; i < gap - 1; i++) en_cycle(1'b0);
        en_cycle(1'b1);
    endtask

    task automatic pulses(input int count, input int dmin, input int dmax);
        for (int i = 0; i < count; i++)
            pulse_after(LENGTH + dmin + int'($urandom_range(0, dmax - dmin)));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) en_cycle(1'b0);
    endtask

    initial begin
        // Reset state.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rst_state",  state, 2'd0);
        check("rst_locked", {1'b0, locked}, 2'd0);
        check("rst_sync",   {1'b0, sync_out}, 2'd0);

        // Clean periodic pulses: HUNT -> CHECK -> LOCK.
        idle(5);
        pulses(6, 0, 0);
        check("periodic_lock", state, 2'd2);

        // Jitter of +/-1 keeps lock.
        pulses(10, -1, 1);
        check("jitter_locked", {1'b0, locked}, 2'd1);

        // +2 jitter while in CHECK drops back to HUNT.
        step(1'b0, 1'b1, 1'b0);
        idle(LENGTH + 2);
        pulses(3, 0, 0);
        check("pre_jit2_check", state, 2'd1);
        pulses(1, 2, 2);
        pulses(2, 0, 0);

        // Lock, then stop pulses: HOLD with coasting, then HUNT.
        pulses(6, 0, 0);
        check("stop_locked", state, 2'd2);
        idle(3 * LENGTH);
        check("stop_hunt", state, 2'd0);

        // Spurious mid-period pulse forces HOLD; next aligned edge restores LOCK.
        pulses(6, 0, 0);
        pulse_after(LENGTH / 2);
        pulse_after(LENGTH / 2);
        pulses(3, 0, 0);
        check("hold_restore", state, 2'd2);

        // Half-rate clock enable with a 16-enabled-cycle period.
        step(1'b0, 1'b1, 1'b0);
        half_en = 1'b1;
        idle(LENGTH + 2);
        pulses(6, 0, 0);
        check("clken_lock", state, 2'd2);
        half_en = 1'b0;

        // Reset while locked with a pending window (input lagging by one).
        pulses(2, 0, 0);
        idle(LENGTH);
        step(1'b0, 1'b1, 1'b1);
        check("midrst_state", state, 2'd0);
        check("midrst_match", {1'b0, match}, 2'd0);
        check("midrst_miss",  {1'b0, miss}, 2'd0);
        check("midrst_sync",  {1'b0, sync_out}, 2'd0);
        pulses(6, 0, 0);
        check("relock", state, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
